// File: rtl/rca_reconfig_controller_if.sv
// Bundle of the configuration, use-gating and storage-write signals for
// rca_reconfig_controller. The slave modport is the controller's view; the
// master modport is the issue/storage side that surrounds it.
interface rca_reconfig_controller_if #(
    parameter int NUM_RCAS   = 4,
    parameter int CFG_DATA_W = 8
);
    localparam int SW = $clog2(NUM_RCAS);

    // Config word stream from issue
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [SW-1:0]         cfg_rca_sel;
    logic [2:0]            cfg_type;
    logic [7:0]            cfg_addr;
    logic [CFG_DATA_W-1:0] cfg_data;
    logic                  cfg_last;

    // Use instruction gating and completion
    logic                  use_valid;
    logic [SW-1:0]         use_rca_sel;
    logic                  use_ready;
    logic                  use_done;
    logic [SW-1:0]         use_done_rca_sel;

    // Write port toward the per-RCA config register banks
    logic                  wr_valid;
    logic [SW-1:0]         wr_rca_sel;
    logic [2:0]            wr_type;
    logic [7:0]            wr_addr;
    logic [CFG_DATA_W-1:0] wr_data;

    // Status
    logic [NUM_RCAS-1:0]   rca_ready;
    logic                  busy;
    logic                  proto_error;

    modport slave (
        input  cfg_valid, cfg_rca_sel, cfg_type, cfg_addr, cfg_data, cfg_last,
        input  use_valid, use_rca_sel, use_done, use_done_rca_sel,
        output cfg_ready, use_ready,
        output wr_valid, wr_rca_sel, wr_type, wr_addr, wr_data,
        output rca_ready, busy, proto_error
    );

    modport master (
        output cfg_valid, cfg_rca_sel, cfg_type, cfg_addr, cfg_data, cfg_last,
        output use_valid, use_rca_sel, use_done, use_done_rca_sel,
        input  cfg_ready, use_ready,
        input  wr_valid, wr_rca_sel, wr_type, wr_addr, wr_data,
        input  rca_ready, busy, proto_error
    );
endinterface

// File: rtl/rca_reconfig_controller.sv
// RCA reconfiguration controller.
// Locks one RCA at a time, drains its in-flight use instructions, then
// forwards its config words to the config register banks with one cycle of
// latency. Tracks per-RCA configured state and outstanding use count, and
// gates use issue on both.
// Optional feature: define RCA_CFG_DRAIN_TIMEOUT_EN to abandon a drain that
// lasts DRAIN_TIMEOUT cycles (the RCA's previous ready state is restored).
module rca_reconfig_controller #(
    parameter int NUM_RCAS        = 4,
    parameter int MAX_OUTSTANDING = 4,
`ifdef RCA_CFG_DRAIN_TIMEOUT_EN
    parameter int DRAIN_TIMEOUT   = 256,
`endif
    parameter int CFG_DATA_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    rca_reconfig_controller_if.slave    bus
);
    localparam int SW = $clog2(NUM_RCAS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic [1:0]          state;
    logic [SW-1:0]       lock_sel;
    logic [NUM_RCAS-1:0] rca_ready_q;
    logic [CW-1:0]       outstanding      [NUM_RCAS];
    logic [CW-1:0]       outstanding_next [NUM_RCAS];
    logic                use_grant;
    logic                use_accept;
    logic                done_error;
    logic                word_ok;

`ifdef RCA_CFG_DRAIN_TIMEOUT_EN
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    logic [TW-1:0] drain_cnt;
    logic          prev_ready;
`endif

    // Use grant, done validation and next outstanding count per RCA
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        use_grant  = rca_ready_q[bus.use_rca_sel] &&
                     (outstanding[bus.use_rca_sel] < CW'(MAX_OUTSTANDING));
        use_accept = bus.use_valid && use_grant;
        done_error = bus.use_done && (outstanding[bus.use_done_rca_sel] == '0);
        for (int i = 0; i < NUM_RCAS; i++) begin
            logic inc;
            logic dec;
            outstanding_next[i] = outstanding[i];
            inc = use_accept && (bus.use_rca_sel == SW'(i));
            dec = bus.use_done && (bus.use_done_rca_sel == SW'(i)) && (outstanding[i] != '0);
            if (inc && !dec)
                outstanding_next[i] = outstanding[i] + 1'b1;
            else if (dec && !inc)
                outstanding_next[i] = outstanding[i] - 1'b1;
        end
    end

    // A word is written only if it targets the locked RCA and a real type
    assign word_ok = (bus.cfg_rca_sel == lock_sel) && (bus.cfg_type != 3'd7);

    // Outstanding use counters; increments are already bounded by use_grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_RCAS; i++)
                outstanding[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            for (int i = 0; i < NUM_RCAS; i++)
                outstanding[i] <= outstanding_next[i];
        end
    end

    // Lock / drain / write sequencing, ready flags and the registered write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            lock_sel        <= '0;
            rca_ready_q     <= '0;
            bus.wr_valid    <= 1'b0;
            bus.wr_rca_sel  <= '0;
            bus.wr_type     <= '0;
            bus.wr_addr     <= '0;
            bus.wr_data     <= '0;
            bus.proto_error <= 1'b0;
`ifdef RCA_CFG_DRAIN_TIMEOUT_EN
            drain_cnt       <= '0;
            prev_ready      <= 1'b0;
`endif
        end else begin
            bus.wr_valid    <= 1'b0;
            bus.proto_error <= done_error;
            case (state)
                IDLE: begin
                    if (bus.cfg_valid) begin
                        lock_sel                     <= bus.cfg_rca_sel;
                        rca_ready_q[bus.cfg_rca_sel] <= 1'b0;
`ifdef RCA_CFG_DRAIN_TIMEOUT_EN
                        prev_ready <= rca_ready_q[bus.cfg_rca_sel];
                        drain_cnt  <= '0;
`endif
                        // Use the post-edge count so a use granted in the lock
                        // cycle itself is still drained before writing.
                        state <= (outstanding_next[bus.cfg_rca_sel] != '0) ? DRAIN : WRITE;
                    end
                end
                DRAIN: begin
                    if (outstanding[lock_sel] == '0)
                        state <= WRITE;
`ifdef RCA_CFG_DRAIN_TIMEOUT_EN
                    else if (drain_cnt == TW'(DRAIN_TIMEOUT - 1)) begin
                        state                 <= IDLE;
                        rca_ready_q[lock_sel] <= prev_ready;
                        bus.proto_error       <= 1'b1;
                    end else
                        drain_cnt <= drain_cnt + 1'b1;
`endif
                end
                WRITE: begin
                    if (bus.cfg_valid) begin
                        if (word_ok) begin
                            bus.wr_valid   <= 1'b1;
                            bus.wr_rca_sel <= bus.cfg_rca_sel;
                            bus.wr_type    <= bus.cfg_type;
                            bus.wr_addr    <= bus.cfg_addr;
                            bus.wr_data    <= bus.cfg_data;
                        end else begin
                            bus.proto_error <= 1'b1;
                        end
                        if (bus.cfg_last) begin
                            rca_ready_q[lock_sel] <= 1'b1;
                            state                 <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cfg_ready = (state == WRITE);
    assign bus.busy      = (state != IDLE);
    assign bus.use_ready = use_grant;
    assign bus.rca_ready = rca_ready_q;

endmodule

// File: tb/tb_rca_reconfig_controller.sv
// Directed self-checking bench for rca_reconfig_controller.
// Inputs change 2 time units after each rising edge; registered outputs are
// checked there, combinational outputs 1 unit after the inputs settle.
module tb_rca_reconfig_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   grants = 0;

    always #5 clk = ~clk;

    rca_reconfig_controller_if #(.NUM_RCAS(4), .CFG_DATA_W(8)) bus ();

    rca_reconfig_controller #(
        .NUM_RCAS(4),
        .MAX_OUTSTANDING(4),
`ifdef RCA_CFG_DRAIN_TIMEOUT_EN
        .DRAIN_TIMEOUT(16),
`endif
        .CFG_DATA_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_cfg(input logic [1:0] sel, input logic [2:0] typ,
                           input logic [7:0] addr, input logic [7:0] data, input logic last);
        bus.cfg_valid   = 1'b1;
        bus.cfg_rca_sel = sel;
        bus.cfg_type    = typ;
        bus.cfg_addr    = addr;
        bus.cfg_data    = data;
        bus.cfg_last    = last;
    endtask

    function automatic logic [31:0] wr_fields();
        return {11'd0, bus.wr_rca_sel, bus.wr_type, bus.wr_addr, bus.wr_data};
    endfunction

    function automatic logic [31:0] exp_fields(input logic [1:0] sel, input logic [2:0] typ,
                                               input logic [7:0] addr, input logic [7:0] data);
        return {11'd0, sel, typ, addr, data};
    endfunction

    initial begin
        bus.cfg_valid = 0; bus.cfg_rca_sel = 0; bus.cfg_type = 0; bus.cfg_addr = 0;
        bus.cfg_data = 0; bus.cfg_last = 0; bus.use_valid = 0; bus.use_rca_sel = 0;
        bus.use_done = 0; bus.use_done_rca_sel = 0;

        // Reset values
        repeat (2) cyc();
        check("rst_rca_ready", 32'(bus.rca_ready), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_cfg_ready", 32'(bus.cfg_ready), 32'h0);
        check("rst_wr_valid", 32'(bus.wr_valid), 32'h0);
        check("rst_proto_error", 32'(bus.proto_error), 32'h0);
        rst = 1'b1;
        cyc();

        // First configuration: three words to RCA1
        set_cfg(2'd1, 3'd2, 8'h10, 8'hA1, 1'b0);
        #1 check("idle_cfg_ready", 32'(bus.cfg_ready), 32'h0);
        cyc();
        check("lock_busy", 32'(bus.busy), 32'h1);
        check("write_cfg_ready", 32'(bus.cfg_ready), 32'h1);
        check("lock_rca_ready", 32'(bus.rca_ready), 32'h0);
        cyc();
        check("w1_valid", 32'(bus.wr_valid), 32'h1);
        check("w1_fields", wr_fields(), exp_fields(2'd1, 3'd2, 8'h10, 8'hA1));
        set_cfg(2'd1, 3'd3, 8'h20, 8'hB2, 1'b0);
        cyc();
        check("w2_valid", 32'(bus.wr_valid), 32'h1);
        check("w2_fields", wr_fields(), exp_fields(2'd1, 3'd3, 8'h20, 8'hB2));
        set_cfg(2'd1, 3'd6, 8'h30, 8'hC3, 1'b1);
        #1 check("pre_last_rca_ready", 32'(bus.rca_ready), 32'h0);
        cyc();
        check("w3_valid", 32'(bus.wr_valid), 32'h1);
        check("w3_fields", wr_fields(), exp_fields(2'd1, 3'd6, 8'h30, 8'hC3));
        check("cfg1_rca_ready", 32'(bus.rca_ready), 32'h2);
        check("cfg1_busy", 32'(bus.busy), 32'h0);
        bus.cfg_valid = 1'b0;
        #1 check("after_last_cfg_ready", 32'(bus.cfg_ready), 32'h0);
        cyc();
        check("after_last_wr_valid", 32'(bus.wr_valid), 32'h0);

        // Drain: two uses on RCA1 then reconfigure RCA1
        bus.use_valid = 1'b1; bus.use_rca_sel = 2'd1;
        #1 check("use1_ready", 32'(bus.use_ready), 32'h1);
        cyc();
        cyc();
        bus.use_valid = 1'b0;
        set_cfg(2'd1, 3'd4, 8'h05, 8'h55, 1'b1);
        cyc();
        check("drain_busy", 32'(bus.busy), 32'h1);
        check("drain_cfg_ready", 32'(bus.cfg_ready), 32'h0);
        check("drain_rca_ready", 32'(bus.rca_ready), 32'h0);
        bus.use_valid = 1'b1;
        #1 check("drain_use_ready", 32'(bus.use_ready), 32'h0);
        bus.use_valid = 1'b0;
        bus.use_done = 1'b1; bus.use_done_rca_sel = 2'd1;
        cyc();
        check("drain_one_left", 32'(bus.cfg_ready), 32'h0);
        cyc();
        bus.use_done = 1'b0;
        check("drain_zero_still_drain", 32'(bus.cfg_ready), 32'h0);
        check("drain_no_proto", 32'(bus.proto_error), 32'h0);
        cyc();
        check("drain_to_write", 32'(bus.cfg_ready), 32'h1);
        check("drain_no_write_yet", 32'(bus.wr_valid), 32'h0);
        cyc();
        check("drain_wr_fields", wr_fields(), exp_fields(2'd1, 3'd4, 8'h05, 8'h55));
        check("drain_wr_valid", 32'(bus.wr_valid), 32'h1);
        check("drain_rca_ready_back", 32'(bus.rca_ready), 32'h2);
        bus.cfg_valid = 1'b0;

        // Outstanding cap on RCA0
        set_cfg(2'd0, 3'd0, 8'h01, 8'h0F, 1'b1);
        cyc();
        cyc();
        bus.cfg_valid = 1'b0;
        check("cfg0_rca_ready", 32'(bus.rca_ready), 32'h3);
        check("cfg0_fields", wr_fields(), exp_fields(2'd0, 3'd0, 8'h01, 8'h0F));
        for (int i = 0; i < 5; i++) begin
            bus.use_valid = 1'b1; bus.use_rca_sel = 2'd0;
            #1 check($sformatf("cap_grant%0d", i), 32'(bus.use_ready), (i < 4) ? 32'h1 : 32'h0);
            if (bus.use_ready) grants++;
            cyc();
        end
        check("cap_total_grants", 32'(grants), 32'd4);
        bus.use_valid = 1'b0; bus.use_rca_sel = 2'd1;
        #1 check("other_rca_unaffected", 32'(bus.use_ready), 32'h1);
        bus.use_rca_sel = 2'd0;
        bus.use_done = 1'b1; bus.use_done_rca_sel = 2'd0;
        cyc();
        bus.use_valid = 1'b1;
        #1 check("simul_ready_at3", 32'(bus.use_ready), 32'h1);
        cyc();
        bus.use_done = 1'b0;
        #1 check("simul_count_kept", 32'(bus.use_ready), 32'h1);
        cyc();
        #1 check("cap_refilled", 32'(bus.use_ready), 32'h0);
        bus.use_valid = 1'b0;

        // use_done on an RCA with nothing outstanding
        bus.use_done = 1'b1; bus.use_done_rca_sel = 2'd1;
        cyc();
        check("idle_done_proto", 32'(bus.proto_error), 32'h1);
        bus.use_done = 1'b0; bus.use_rca_sel = 2'd1;
        #1 check("idle_done_count0", 32'(bus.use_ready), 32'h1);
        cyc();
        check("idle_done_pulse_end", 32'(bus.proto_error), 32'h0);

        // Mismatched select and reserved type while locked to RCA2
        set_cfg(2'd2, 3'd1, 8'h00, 8'h20, 1'b0);
        cyc();
        check("lock2_cfg_ready", 32'(bus.cfg_ready), 32'h1);
        set_cfg(2'd3, 3'd2, 8'h40, 8'hDD, 1'b0);
        cyc();
        check("badsel_no_write", 32'(bus.wr_valid), 32'h0);
        check("badsel_proto", 32'(bus.proto_error), 32'h1);
        set_cfg(2'd2, 3'd7, 8'h41, 8'hEE, 1'b0);
        cyc();
        check("type7_no_write", 32'(bus.wr_valid), 32'h0);
        check("type7_proto", 32'(bus.proto_error), 32'h1);
        set_cfg(2'd2, 3'd5, 8'h07, 8'h77, 1'b0);
        cyc();
        check("lock2_w1_valid", 32'(bus.wr_valid), 32'h1);
        check("lock2_w1_fields", wr_fields(), exp_fields(2'd2, 3'd5, 8'h07, 8'h77));
        check("lock2_no_proto", 32'(bus.proto_error), 32'h0);
        check("lock2_not_ready", 32'(bus.rca_ready), 32'h3);

        // Asynchronous reset in the middle of the RCA2 sequence
        set_cfg(2'd2, 3'd6, 8'h08, 8'h88, 1'b0);
        #1 rst = 1'b0;
        #1;
        check("arst_wr_valid", 32'(bus.wr_valid), 32'h0);
        check("arst_rca_ready", 32'(bus.rca_ready), 32'h0);
        check("arst_busy", 32'(bus.busy), 32'h0);
        check("arst_cfg_ready", 32'(bus.cfg_ready), 32'h0);
        check("arst_use_ready", 32'(bus.use_ready), 32'h0);
        bus.cfg_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        check("post_rst_rca_ready", 32'(bus.rca_ready), 32'h0);
        check("post_rst_busy", 32'(bus.busy), 32'h0);

`ifdef RCA_CFG_DRAIN_TIMEOUT_EN
        // Drain timeout: one use on RCA0 never completes
        set_cfg(2'd0, 3'd0, 8'h00, 8'h00, 1'b1);
        cyc();
        cyc();
        bus.cfg_valid = 1'b0;
        bus.use_valid = 1'b1; bus.use_rca_sel = 2'd0;
        cyc();
        bus.use_valid = 1'b0;
        set_cfg(2'd0, 3'd0, 8'h02, 8'h22, 1'b1);
        cyc();
        bus.cfg_valid = 1'b0;
        check("to_drain_ready", 32'(bus.rca_ready), 32'h0);
        repeat (15) cyc();
        check("to_still_busy", 32'(bus.busy), 32'h1);
        cyc();
        check("to_idle", 32'(bus.busy), 32'h0);
        check("to_ready_restored", 32'(bus.rca_ready), 32'h1);
        check("to_proto", 32'(bus.proto_error), 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
